// File: rtl/mask_gen_pkg.sv
// mask_gen_pkg: shared constants, state encoding and dimension helpers
// used by row_mask_serializer and its word-select sub-module.
package mask_gen_pkg;

  // Width of every dimension/counter port (rows, pixels, word index).
  localparam int DIM_W     = 11;
  // Default output word width.
  localparam int OUT_W_DEF = 32;

  typedef logic [DIM_W-1:0] dim_t;

  // Serializer state encoding.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

  // Round-up integer division, used to turn a pixel width into a word count.
  function automatic dim_t ceil_div(input dim_t num, input int den);
    int q;
    q = (int'(num) + den - 1) / den;
    return dim_t'(q);
  endfunction

  // A zero or out-of-range dimension selects the maximum supported size.
  function automatic dim_t clamp_dim(input dim_t val, input dim_t max_val);
    if ((val == '0) || (val > max_val)) begin
      return max_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/mask_word_select.sv
// mask_word_select: combinational mux that picks word k out of a captured
// row mask. Bit j of the result is row[k*OUT_W + j]; any bit whose pixel
// position is at or beyond the active width is forced to 0.
module mask_word_select
  import mask_gen_pkg::*;
#(
  parameter int ROW_W = 1920,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [0:ROW_W-1]  row_i,
  input  logic [DIM_W-1:0]  k_i,
  input  logic [DIM_W-1:0]  w_i,
  output logic [OUT_W-1:0]  word_o
);

  localparam int IDX_W = $clog2(ROW_W + OUT_W) + 1;

  logic [IDX_W-1:0] base;
  logic [0:ROW_W-1] shifted;

  // Bring pixel k*OUT_W to position 0, then gate each bit by the active width.
  always_comb begin
    base    = IDX_W'(k_i) * IDX_W'(OUT_W);
    shifted = row_i << base;
    word_o  = '0;
    for (int j = 0; j < OUT_W; j++) begin
      if ((base + IDX_W'(j)) < IDX_W'(w_i)) begin
        word_o[j] = shifted[j];
      end
    end
  end

endmodule

// File: rtl/row_mask_serializer.sv
// row_mask_serializer: captures one row mask from the mask generator and
// streams it to the sensor mask interface as OUT_W-bit words over a
// valid/ready handshake, with line and frame markers.
//
// Optional build macro ROW_MASK_SER_DBUF_EN adds a second row buffer so a
// new row can be accepted while the current one is still being sent, and
// rows stream back-to-back without an idle cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no row held; ready to capture the next row
// SEND  | presenting word k of the held row, k = 0 .. NW-1
module row_mask_serializer
  import mask_gen_pkg::*;
#(
  parameter int max_image_sensor_w = 1920,
  parameter int max_image_sensor_h = 1080,
  parameter int OUT_W              = OUT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic [DIM_W-1:0]              image_sensor_w,
  input  logic [DIM_W-1:0]              image_sensor_h,
  input  logic [0:max_image_sensor_w-1] mg_mask,
  input  logic                          rp_valid,
  output logic                          row_in_ready,
  input  logic                          frame_restart,
  output logic [OUT_W-1:0]              sensor_data,
  output logic                          sensor_valid,
  input  logic                          sensor_ready,
  output logic                          sensor_sol,
  output logic                          sensor_eol,
  output logic                          sensor_sof,
  output logic                          sensor_eof,
  output logic [DIM_W-1:0]              row_idx
);

  localparam dim_t MAX_W_D = dim_t'(max_image_sensor_w);
  localparam dim_t MAX_H_D = dim_t'(max_image_sensor_h);
  localparam dim_t ONE     = dim_t'(1);

  state_t state_q, state_d;
  dim_t   k_q,     k_d;
  dim_t   row_q,   row_d;
  dim_t   w_q,     w_d;
  dim_t   h_q,     h_d;
  dim_t   nw_q,    nw_d;
  logic [0:max_image_sensor_w-1] buf_q, buf_d;

`ifdef ROW_MASK_SER_DBUF_EN
  dim_t   w2_q,    w2_d;
  dim_t   h2_q,    h2_d;
  dim_t   nw2_q,   nw2_d;
  logic   full2_q, full2_d;
  logic [0:max_image_sensor_w-1] buf2_q, buf2_d;
`endif

  dim_t   w_in, h_in, nw_in;
  logic   sending, capture, xfer, last_word, row_wrap;
  logic [OUT_W-1:0] word_sel;

  // Effective dimensions of the row being offered, frozen at capture time.
  assign w_in  = clamp_dim(image_sensor_w, MAX_W_D);
  assign h_in  = clamp_dim(image_sensor_h, MAX_H_D);
  assign nw_in = ceil_div(w_in, OUT_W);

  assign sending   = (state_q == SEND);
  assign capture   = clk_en && rp_valid && row_in_ready;
  assign xfer      = clk_en && sending && sensor_ready;
  assign last_word = (k_q == (nw_q - ONE));
  // >= rather than == keeps the counter bounded if H shrank mid-frame.
  assign row_wrap  = (row_q >= (h_q - ONE));

`ifdef ROW_MASK_SER_DBUF_EN
  assign row_in_ready = !full2_q;
`else
  assign row_in_ready = (state_q == IDLE);
`endif

  mask_word_select #(
    .ROW_W (max_image_sensor_w),
    .OUT_W (OUT_W)
  ) u_word_sel (
    .row_i  (buf_q),
    .k_i    (k_q),
    .w_i    (w_q),
    .word_o (word_sel)
  );

  // Next-state: capture, word advance, row advance and restart handling.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    nw_d    = nw_q;
    buf_d   = buf_q;
`ifdef ROW_MASK_SER_DBUF_EN
    w2_d    = w2_q;
    h2_d    = h2_q;
    nw2_d   = nw2_q;
    full2_d = full2_q;
    buf2_d  = buf2_q;
`endif

    if (clk_en) begin
      if (frame_restart) begin
        // Abort wins over any capture or transfer in the same cycle.
        state_d = IDLE;
        k_d     = '0;
        row_d   = '0;
`ifdef ROW_MASK_SER_DBUF_EN
        full2_d = 1'b0;
`endif
      end else begin
        if (state_q == IDLE) begin
          if (capture) begin
            buf_d   = mg_mask;
            w_d     = w_in;
            h_d     = h_in;
            nw_d    = nw_in;
            k_d     = '0;
            state_d = SEND;
          end
        end else if (xfer && last_word) begin
          row_d = row_wrap ? '0 : (row_q + ONE);
          k_d   = '0;
`ifdef ROW_MASK_SER_DBUF_EN
          if (full2_q) begin
            buf_d   = buf2_q;
            w_d     = w2_q;
            h_d     = h2_q;
            nw_d    = nw2_q;
            full2_d = 1'b0;
          end else if (capture) begin
            // Row arriving exactly on the eol word goes straight to the
            // primary buffer so the stream stays gap-free.
            buf_d   = mg_mask;
            w_d     = w_in;
            h_d     = h_in;
            nw_d    = nw_in;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (xfer) begin
          k_d = k_q + ONE;
        end

`ifdef ROW_MASK_SER_DBUF_EN
        // Rows offered mid-send park in the second buffer.
        if (sending && capture && !(xfer && last_word)) begin
          buf2_d  = mg_mask;
          w2_d    = w_in;
          h2_d    = h_in;
          nw2_d   = nw_in;
          full2_d = 1'b1;
        end
`endif
      end
    end
  end

  // State and buffer registers; reset discards any partial row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      w_q     <= MAX_W_D;
      h_q     <= MAX_H_D;
      nw_q    <= '0;
      buf_q   <= '0;
`ifdef ROW_MASK_SER_DBUF_EN
      w2_q    <= MAX_W_D;
      h2_q    <= MAX_H_D;
      nw2_q   <= '0;
      full2_q <= 1'b0;
      buf2_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      nw_q    <= nw_d;
      buf_q   <= buf_d;
`ifdef ROW_MASK_SER_DBUF_EN
      w2_q    <= w2_d;
      h2_q    <= h2_d;
      nw2_q   <= nw2_d;
      full2_q <= full2_d;
      buf2_q  <= buf2_d;
`endif
    end
  end

  // Output word and markers; everything reads 0 while no word is presented.
  always_comb begin
    sensor_valid = sending;
    sensor_data  = sending ? word_sel : '0;
    sensor_sol   = sending && (k_q == '0);
    sensor_eol   = sending && last_word;
    sensor_sof   = sensor_sol && (row_q == '0);
    sensor_eof   = sensor_eol && (row_q == (h_q - ONE));
    row_idx      = row_q;
  end

endmodule

// File: tb/tb_row_mask_serializer.sv
// Self-checking bench for row_mask_serializer. Expected words and markers
// come from a pixel-level model of the row (bit j of word k is pixel
// k*OUT_W+j when inside the active width) and a simple row counter.
module tb_row_mask_serializer;

  localparam int MW = 1920;
  localparam int MH = 1080;
  localparam int OW = 32;
`ifdef ROW_MASK_SER_DBUF_EN
  localparam int DBUF = 1;
  localparam int GAP  = 1;
`else
  localparam int DBUF = 0;
  localparam int GAP  = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic [10:0]   image_sensor_w;
  logic [10:0]   image_sensor_h;
  logic [0:MW-1] mg_mask;
  logic          rp_valid;
  logic          row_in_ready;
  logic          frame_restart;
  logic [OW-1:0] sensor_data;
  logic          sensor_valid;
  logic          sensor_ready;
  logic          sensor_sol;
  logic          sensor_eol;
  logic          sensor_sof;
  logic          sensor_eof;
  logic [10:0]   row_idx;

  int checks   = 0;
  int failures = 0;
  int exp_row  = 0;

  always #5 clk = ~clk;

  row_mask_serializer #(
    .max_image_sensor_w (MW),
    .max_image_sensor_h (MH),
    .OUT_W              (OW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .image_sensor_w (image_sensor_w),
    .image_sensor_h (image_sensor_h),
    .mg_mask        (mg_mask),
    .rp_valid       (rp_valid),
    .row_in_ready   (row_in_ready),
    .frame_restart  (frame_restart),
    .sensor_data    (sensor_data),
    .sensor_valid   (sensor_valid),
    .sensor_ready   (sensor_ready),
    .sensor_sol     (sensor_sol),
    .sensor_eol     (sensor_eol),
    .sensor_sof     (sensor_sof),
    .sensor_eof     (sensor_eof),
    .row_idx        (row_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int v, input int mx);
    return ((v == 0) || (v > mx)) ? mx : v;
  endfunction

  function automatic logic [OW-1:0] exp_word(input logic [0:MW-1] m, input int w, input int k);
    logic [OW-1:0] r;
    r = '0;
    for (int j = 0; j < OW; j++) begin
      if (k * OW + j < w) r[j] = m[k * OW + j];
    end
    return r;
  endfunction

  function automatic logic [0:MW-1] rand_mask();
    logic [0:MW-1] m;
    for (int i = 0; i < MW; i++) m[i] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, row_in_ready, 1);
    chk({tag, "_valid"}, sensor_valid, 0);
    chk({tag, "_data"}, sensor_data, 0);
    chk({tag, "_sol"}, sensor_sol, 0);
    chk({tag, "_eol"}, sensor_eol, 0);
    chk({tag, "_sof"}, sensor_sof, 0);
    chk({tag, "_eof"}, sensor_eof, 0);
    chk({tag, "_row"}, row_idx, 0);
  endtask

  // Called at posedge+1 in IDLE; offers a row together with the restart.
  task automatic do_restart();
    frame_restart  = 1'b1;
    rp_valid       = 1'b1;
    image_sensor_w = 11'd64;
    mg_mask        = rand_mask();
    @(posedge clk); #1;
    frame_restart = 1'b0;
    rp_valid      = 1'b0;
    #4;
    chk("restart_drop_valid", sensor_valid, 0);
    chk("restart_row", row_idx, 0);
    chk("restart_rdy", row_in_ready, 1);
    exp_row = 0;
    @(posedge clk); #1;
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: clk_en gaps;
  // 3: frame_restart at word 1; 4: rst_n pulse at word 1.
  task automatic run_row(input logic [0:MW-1] m, input int w_raw, input int h_raw, input int mode);
    int w, h, nw, k, c, guard;
    w  = eff(w_raw, MW);
    h  = eff(h_raw, MH);
    nw = (w + OW - 1) / OW;
    mg_mask        = m;
    image_sensor_w = 11'(w_raw);
    image_sensor_h = 11'(h_raw);
    rp_valid       = 1'b1;
    sensor_ready   = 1'b0;
    guard = 0;
    #4;
    while (!row_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("capture_wait", (guard < 100), 1);
    @(posedge clk); #1;
    // Change everything upstream: the captured row must not follow.
    rp_valid       = 1'b0;
    mg_mask        = rand_mask();
    image_sensor_w = 11'($urandom);
    image_sensor_h = 11'($urandom);
    k = 0;
    c = 0;
    while (k < nw && c < 1000) begin
      clk_en       = 1'b1;
      sensor_ready = 1'b1;
      if (mode == 1) sensor_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (mode == 2) clk_en = !(((c % 4) == 1) || ((c % 4) == 2));
      if (mode == 4 && k == 1) begin
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_row = 0;
        #4;
        chk_reset("post_rst");
        @(posedge clk); #1;
        break;
      end
      if (mode == 3 && k == 1) begin
        frame_restart = 1'b1;
        rp_valid      = 1'b1;
      end
      #4;
      chk("valid", sensor_valid, 1);
      chk("data", sensor_data, exp_word(m, w, k));
      chk("sol", sensor_sol, (k == 0));
      chk("eol", sensor_eol, (k == nw - 1));
      chk("sof", sensor_sof, (k == 0) && (exp_row == 0));
      chk("eof", sensor_eof, (k == nw - 1) && (exp_row == h - 1));
      chk("row_idx", row_idx, exp_row);
      chk("rdy_in_send", row_in_ready, DBUF);
      if (mode == 3 && k == 1) begin
        @(posedge clk); #1;
        frame_restart = 1'b0;
        rp_valid      = 1'b0;
        exp_row       = 0;
        #4;
        chk("restart_valid", sensor_valid, 0);
        chk("restart_row_idx", row_idx, 0);
        chk("restart_rdy", row_in_ready, 1);
        @(posedge clk); #1;
        break;
      end
      if (sensor_ready && clk_en) begin
        k++;
        if (k == nw) exp_row = (exp_row == h - 1) ? 0 : exp_row + 1;
      end
      @(posedge clk); #1;
      c++;
    end
    clk_en       = 1'b1;
    sensor_ready = 1'b0;
  endtask

  // Two full-width rows offered back-to-back; measures the gap between them.
  task automatic back_to_back();
    logic [0:MW-1] ma, mb;
    int caps, kidx, rowsel, a_last, b_first;
    logic cap_now;
    ma = rand_mask();
    mb = rand_mask();
    image_sensor_w = 11'd1920;
    image_sensor_h = 11'd0;
    sensor_ready   = 1'b1;
    mg_mask        = ma;
    rp_valid       = 1'b1;
    caps = 0; kidx = 0; rowsel = 0; a_last = -100; b_first = 100;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #4;
      if (sensor_valid) begin
        chk("b2b_data", sensor_data, exp_word((rowsel == 0) ? ma : mb, MW, kidx));
        chk("b2b_sol", sensor_sol, (kidx == 0));
        chk("b2b_row", row_idx, exp_row);
        if (rowsel == 0 && kidx == 59) a_last = cyc;
        if (rowsel == 1 && kidx == 0) b_first = cyc;
        kidx++;
        if (kidx == 60) begin
          kidx    = 0;
          rowsel++;
          exp_row = (exp_row == MH - 1) ? 0 : exp_row + 1;
        end
      end
      cap_now = rp_valid && row_in_ready;
      @(posedge clk); #1;
      if (cap_now) begin
        caps++;
        if (caps == 1) mg_mask = mb;
        else rp_valid = 1'b0;
      end
      if (rowsel == 2) break;
    end
    chk("b2b_done", rowsel, 2);
    chk("b2b_gap", b_first - a_last, GAP);
    rp_valid     = 1'b0;
    sensor_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:MW-1] m;
    rst_n = 1'b0; clk_en = 1'b1; image_sensor_w = '0; image_sensor_h = '0;
    mg_mask = '0; rp_valid = 1'b0; frame_restart = 1'b0; sensor_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #4;
    chk_reset("reset");
    @(posedge clk); #1;

    // W=64, H=2, pixels with i%3==0 set: rows 0, 1, then wrap to 0.
    for (int i = 0; i < MW; i++) m[i] = ((i % 3) == 0);
    run_row(m, 64, 2, 0);
    run_row(m, 64, 2, 0);
    run_row(m, 64, 2, 0);

    // Restart from IDLE with a coincident row offer: row dropped.
    do_restart();

    // W=40 all ones: second word keeps only 8 pixels.
    m = '1;
    run_row(m, 40, 0, 0);

    // Width clamping and edge widths with random masks.
    run_row(rand_mask(), 0, 0, 0);
    run_row(rand_mask(), 2000, 2000, 0);
    run_row(rand_mask(), 1, 0, 0);
    run_row(rand_mask(), 33, 0, 0);
    run_row(rand_mask(), 1919, 0, 0);
    run_row(rand_mask(), 11'($urandom_range(2, 1920)), 0, 0);

    // Stalls on the sensor side and clock-enable gaps.
    run_row(rand_mask(), 100, 0, 1);
    run_row(rand_mask(), 200, 0, 2);

    // Frame restart at word 1 of row 3.
    do_restart();
    for (int r = 0; r < 3; r++) run_row(rand_mask(), 64, 10, 0);
    run_row(rand_mask(), 64, 10, 3);
    run_row(rand_mask(), 64, 10, 0);
    run_row(rand_mask(), 64, 10, 0);

    // Asynchronous reset in the middle of row 2.
    run_row(rand_mask(), 64, 10, 4);
    run_row(rand_mask(), 96, 10, 0);

    // H=1, NW=1: every marker on the single word of every row.
    do_restart();
    run_row(rand_mask(), 1, 1, 0);
    run_row(rand_mask(), 32, 1, 0);

    back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_mask_serializer.md
Name: row_mask_serializer

Overview:
- Downstream consumer of the mask generation stage.
- Captures one full row mask (max_image_sensor_w bits) when the mask generator asserts rp_valid.
- Streams the row to the image-sensor mask interface as OUT_W-bit words, using a valid/ready handshake.
- Tracks row position within the frame and emits start/end-of-line and start/end-of-frame markers.

Parameters:
max_image_sensor_w, 1920, maximum sensor width in pixels; width of the captured row.
max_image_sensor_h, 1080, maximum sensor height in rows.
OUT_W, 32, output word width in bits.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
clk_en  input  1  clock enable; when low, all state and outputs are frozen
image_sensor_w  input  11  active row width in pixels
image_sensor_h  input  11  active frame height in rows
mg_mask  input  [0:max_image_sensor_w-1]  row mask from the mask generator
rp_valid  input  1  mg_mask valid
row_in_ready  output  1  row can be captured this cycle
frame_restart  input  1  synchronous abort; the next row becomes row 0
sensor_data  output  OUT_W  mask word; sensor_data[j] = mg_mask[k*OUT_W+j]
sensor_valid  output  1  sensor_data valid
sensor_ready  input  1  sensor accepts the word
sensor_sol  output  1  first word of a row
sensor_eol  output  1  last word of a row
sensor_sof  output  1  first word of row 0
sensor_eof  output  1  last word of row H-1
row_idx  output  11  row index of the word currently presented

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except row_in_ready = 1; state = IDLE; row counter = 0; word counter = 0.
- Effective dimensions:
  - W = image_sensor_w, but 0 or any value > max_image_sensor_w maps to max_image_sensor_w. H is derived from image_sensor_h the same way.
  - Both are sampled at row capture and held constant for that row.
- Word count: NW = ceil(W/OUT_W), computed at capture.
- Last-word padding: bits at or beyond W in the last word are driven 0.
- FSM states:
  - IDLE: row_in_ready = 1. When rp_valid && row_in_ready, capture mg_mask, W and H, then go to SEND.
  - SEND: sensor_valid = 1 and the word index k runs from 0 to NW-1.
    - A word transfers only when sensor_valid && sensor_ready.
    - While sensor_ready is low, sensor_data and all marker outputs stay stable.
    - When word NW-1 transfers: row counter increments, or wraps to 0 if it equals H-1. Then go to IDLE, or reload from the second buffer when the optional feature is enabled.
- Latency: row captured in cycle t; word 0 is presented in cycle t+1. With sensor_ready held high, one word transfers per cycle.
- Markers are combinational from the counters and are valid only while sensor_valid = 1:
  - sensor_sol = (k==0)
  - sensor_eol = (k==NW-1)
  - sensor_sof = sol && (row==0)
  - sensor_eof = eol && (row==H-1)
- NW==1: sol and eol assert on the same word.
- frame_restart:
  - Clears the row counter, word counter and any buffered row; state goes to IDLE.
  - Takes priority over a simultaneous capture or transfer; the row offered that cycle is dropped.
- clk_en low: there are no captures or transfers and all counters hold. sensor_valid holds its value, but the bench must not rely on any transfer occurring during that cycle.
- rp_valid while row_in_ready = 0: ignored. The upstream block holds rp_valid until accepted.
- Reset mid-row: the partial row is discarded and the block returns to its reset values immediately.

Optional Feature:
- Macro: ROW_MASK_SER_DBUF_EN (double buffering).
- Defined:
  - Adds a second row buffer; row_in_ready = 1 whenever that buffer is empty, including during SEND.
  - On eol transfer with the buffer full, the next row's word 0 appears in the next cycle, with no idle gap.
  - Capture and eol transfer in the same cycle are both legal.
- Undefined: a single buffer; row_in_ready = 1 only in IDLE, so at least one idle cycle separates rows.

Decomposition:
- Shared package mask_gen_pkg holds:
  - state enum (IDLE, SEND)
  - OUT_W default and the 11-bit dimension width constant
  - function ceil_div
  - function clamp_dim
- Natural sub-module: mask_word_select, a combinational word mux that takes the row buffer, k and W and returns the padded word.

Test Plan:
- W=64, H=2, mask bit pattern i%3==0, sensor_ready=1 -> 2 words per row; sol/eol on words 0/1; sof on row 0 word 0; eof on row 1 word 1; sensor_data[0] of word 0 = 1.
- W=40 with an all-ones mask -> NW=2; word 1 = 0x000000FF (bits 8..31 zero).
- sensor_ready toggled 1,0,0,1 during SEND -> sensor_data, sol and eol stable while stalled; no word skipped or repeated.
- frame_restart asserted at word 1 of row 3 -> next row presents row_idx=0 with sof=1; the offered row is dropped if it coincides with the restart.
- rst_n pulled low mid-row -> all outputs at reset values asynchronously; after release, the first captured row has row_idx=0.
- With ROW_MASK_SER_DBUF_EN, back-to-back rp_valid, W=1920 -> 60 words per row; row 1 word 0 immediately follows row 0 word 59; without the macro, exactly one idle cycle between them.
